i2c_slave_mem: RTL
==================

# i2c_slave_mem

Parametrised I2C target that exposes a byte-addressed register space behind a standard I2C device address, with an internal register pointer, auto-increment, repeated-start support and input glitch filtering. It sits between the SFP-side two-wire bus and a local register file or RAM. It generalises the single-byte I2C slave into an EEPROM-style (A0h/A2h) memory target.

## Interface
- `ADRS`, 7'b1010000, 7-bit device address this target answers to.
- `ADDR_W`, 8, register pointer width; address space is 2^ADDR_W bytes.
- `FILTER_LEN`, 3, number of consecutive equal synchronised samples required before a line level is accepted (1..15).

- `clk` input 1, system clock; must be at least 20× the SCL frequency.
- `reset_n` input 1, asynchronous active-low reset.
- `scl` input 1, bus clock.
- `sda` inout 1, open-drain data; driven only as 1'b0 or 1'bz.
- `mem_addr` output ADDR_W, register address for the current access.
- `mem_wdata` output 8, write data.
- `mem_we` output 1, one-cycle write strobe.
- `mem_re` output 1, one-cycle read strobe.
- `mem_rdata` input 8, read data, valid exactly 1 clk after `mem_re`.
- `busy` output 1, high from an address-matched START until STOP or mismatch.

## Operation
- Both lines pass through a 2-flop synchroniser and a FILTER_LEN stability filter. All logic uses filtered levels only.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. They are mutually exclusive.
- SDA is sampled on filtered SCL rising edges. SDA drive changes 1 clk after a filtered SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE/IGNORE → ADDR on START.
- ADDR shifts 8 bits, MSB first.
  - Address match: → ADDR_ACK and drive 0 for the ACK bit.
  - Mismatch: → IGNORE and leave SDA released.
- ADDR_ACK exit, on the next SCL falling edge:
  - R/W=0 → PTR.
  - R/W=1 → RDATA.
- PTR: the 8th bit loads the pointer with the low ADDR_W bits of the byte (ADDR_W ≤ 8); then PTR_ACK (ACK) → WDATA.
- WDATA: on the 8th bit, pulse `mem_we` with `mem_addr`=pointer and `mem_wdata`=byte. Then pointer+1 and → WDATA_ACK (ACK) → WDATA.
- Read fetch: `mem_re` pulses in the cycle the R bit is sampled, and again when the master ACK is sampled in RDATA_ACK. `mem_rdata` is loaded into the tx shifter 1 clk later, and the pointer increments on the load.
- RDATA drives 0 or releases SDA for each bit, MSB first. After 8 bits → RDATA_ACK, with SDA released.
  - Master ACK → RDATA.
  - Master NACK → IGNORE.
- The pointer wraps from 2^ADDR_W-1 to 0.
- The pointer is retained across STOP and repeated START; only reset clears it.
- STOP in any state → IDLE, SDA released, `busy`=0.
- START in any state → ADDR. This is the repeated START; the bit counter clears.
- STOP has priority over every FSM transition. Reset has priority over all.

## Timing
- Reset values: state IDLE, pointer 0, SDA released, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `busy`=0.
- Pin-to-filtered latency is 2+FILTER_LEN clk. A pulse shorter than FILTER_LEN clk is ignored.
- `mem_we` asserts 1 clk after the 8th-bit SCL rise is detected. `mem_addr` and `mem_wdata` are stable in that same cycle.
- The tx shifter is loaded 2 clk after `mem_re`-triggering detection, well before the next SCL fall.
- `busy` rises 1 clk after the ADRS match is detected and falls 1 clk after STOP.
- Reset mid-transfer releases SDA immediately (asynchronously) and aborts any pending strobe.

## Structure
- Package `i2c_pkg` holds:
  - the state enum typedef `i2c_mem_state_t`;
  - constants `I2C_BYTE_W`=8, `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1.
- Sub-module `i2c_line_filter` provides synchroniser, stability filter and rise/fall edge pulses for one line. It is instantiated for `scl` and `sda`.

## Test plan
- Write 0x50 W, pointer 0x10, data 0xA5, 0x3C, STOP → `mem_we` twice: (0x10, 0xA5) then (0x11, 0x3C); all four bytes ACKed.
- Write pointer 0x20, repeated START, 0x50 R, master ACK, ACK, NACK with `mem_rdata` = addr^0xFF → bus bytes 0xDF, 0xDE, 0xDD; then SDA released; pointer ends at 0x23.
- Address 0x51 W → no ACK, no strobes, `busy`=0, SDA never driven until the next START.
- Pointer 0xFF, write 0x11, 0x22 → writes land at 0xFF then 0x00.
- 1-clk SDA glitch while SCL is high (FILTER_LEN=3) → no START/STOP detected, state unchanged.
- Assert `reset_n` mid-RDATA while driving 0 → SDA becomes Z immediately; after release, state is IDLE and pointer is 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory target.
// Imported by the target top and its testbench.
package i2c_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_mem_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus stability filter for one bus line,
// with registered rise/fall pulses aligned to the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_lvl;
  logic       r_rise;
  logic       r_fall;
  logic [3:0] r_cnt;
  logic       w_diff;
  logic       w_take;

  assign w_diff = (r_s2 != r_lvl);
  assign w_take = w_diff &&
                  (r_cnt == 4'(FILTER_LEN - 1));

  // Idle bus level is high, so start there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_line;
      r_s2   <= r_s1;
      r_rise <= w_take && r_s2;
      r_fall <= w_take && !r_s2;
      if (w_take) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_mem.sv
// EEPROM-style I2C target: device address, register pointer with
// auto-increment, byte writes/reads into a local memory port.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADRS       = 7'b1010000,
  parameter int         ADDR_W     = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [I2C_BYTE_W-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [I2C_BYTE_W-1:0] mem_rdata,
  output logic                  busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic w_rx_st, w_last, w_done;
  logic [I2C_BYTE_W-1:0] w_byte;

  i2c_mem_state_t r_state, nx_state;
  logic [3:0]            r_bitcnt, nx_bitcnt;
  logic [I2C_BYTE_W-2:0] r_rx, nx_rx;
  logic [I2C_BYTE_W-1:0] r_tx, nx_tx;
  logic [ADDR_W-1:0]     r_ptr, nx_ptr;
  logic [ADDR_W-1:0]     r_addr, nx_addr;
  logic [I2C_BYTE_W-1:0] r_wdata, nx_wdata;
  logic r_oe, nx_oe;
  logic r_phase, nx_phase;
  logic r_rw, nx_rw;
  logic r_we, nx_we;
  logic r_re, nx_re;
  logic r_re_d;
  logic r_busy, nx_busy;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_line  (scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_line  (sda),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall && w_scl;
  assign w_stop  = w_sda_rise && w_scl;
  assign w_byte  = {r_rx, w_sda};
  assign w_last  = (r_bitcnt == 4'd7);
  assign w_rx_st = (r_state == ST_ADDR) ||
                   (r_state == ST_PTR) ||
                   (r_state == ST_WDATA);
  assign w_done  = w_rx_st && w_scl_rise && w_last;

  always_comb begin
    nx_state  = r_state;
    nx_bitcnt = r_bitcnt;
    nx_rx     = r_rx;
    nx_tx     = r_tx;
    nx_ptr    = r_ptr;
    nx_addr   = r_addr;
    nx_wdata  = r_wdata;
    nx_oe     = r_oe;
    nx_phase  = r_phase;
    nx_rw     = r_rw;
    nx_we     = 1'b0;
    nx_re     = 1'b0;
    nx_busy   = r_busy;
    // Fetched byte lands one cycle after the read strobe.
    if (r_re_d) begin
      nx_tx  = mem_rdata;
      nx_ptr = r_ptr + ADDR_W'(1);
    end
    if (w_stop) begin
      nx_state  = ST_IDLE;
      nx_oe     = 1'b0;
      nx_busy   = 1'b0;
      nx_bitcnt = '0;
      nx_phase  = 1'b0;
    end else if (w_start) begin
      nx_state  = ST_ADDR;
      nx_oe     = 1'b0;
      nx_bitcnt = '0;
      nx_phase  = 1'b0;
    end else begin
      if (w_rx_st && w_scl_rise) begin
        nx_rx     = w_byte[I2C_BYTE_W-2:0];
        nx_bitcnt = w_last ? 4'd0 : r_bitcnt + 4'd1;
        nx_phase  = 1'b0;
      end
      case (r_state)
        ST_ADDR: if (w_done) begin
          if (w_byte[7:1] == ADRS) begin
            nx_state = ST_ADDR_ACK;
            nx_busy  = 1'b1;
            nx_rw    = w_sda;
            if (w_sda) begin
              nx_re   = 1'b1;
              nx_addr = r_ptr;
            end
          end else begin
            nx_state = ST_IGNORE;
            nx_busy  = 1'b0;
          end
        end
        ST_PTR: if (w_done) begin
          nx_ptr   = w_byte[ADDR_W-1:0];
          nx_state = ST_PTR_ACK;
        end
        ST_WDATA: if (w_done) begin
          nx_we    = 1'b1;
          nx_addr  = r_ptr;
          nx_wdata = w_byte;
          nx_ptr   = r_ptr + ADDR_W'(1);
          nx_state = ST_WDATA_ACK;
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
          if (w_scl_fall) begin
            // First fall opens the ACK slot, second closes it.
            nx_phase = !r_phase;
            nx_oe    = !r_phase;
            if (r_phase) begin
              if (r_state == ST_ADDR_ACK && r_rw) begin
                nx_state  = ST_RDATA;
                nx_oe     = !r_tx[7];
                nx_bitcnt = '0;
              end else if (r_state == ST_ADDR_ACK) begin
                nx_state = ST_PTR;
              end else begin
                nx_state = ST_WDATA;
              end
            end
          end
        ST_RDATA: begin
          if (w_scl_rise) nx_bitcnt = r_bitcnt + 4'd1;
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              nx_state  = ST_RDATA_ACK;
              nx_oe     = 1'b0;
              nx_bitcnt = '0;
              nx_phase  = 1'b0;
            end else begin
              nx_oe = !r_tx[6];
              nx_tx = {r_tx[6:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              nx_re    = 1'b1;
              nx_addr  = r_ptr;
              nx_phase = 1'b1;
            end else begin
              nx_state = ST_IGNORE;
            end
          end else if (w_scl_fall && r_phase) begin
            nx_state  = ST_RDATA;
            nx_oe     = !r_tx[7];
            nx_bitcnt = '0;
            nx_phase  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_ptr    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_oe     <= 1'b0;
      r_phase  <= 1'b0;
      r_rw     <= 1'b0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_re_d   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= nx_state;
      r_bitcnt <= nx_bitcnt;
      r_rx     <= nx_rx;
      r_tx     <= nx_tx;
      r_ptr    <= nx_ptr;
      r_addr   <= nx_addr;
      r_wdata  <= nx_wdata;
      r_oe     <= nx_oe;
      r_phase  <= nx_phase;
      r_rw     <= nx_rw;
      r_we     <= nx_we;
      r_re     <= nx_re;
      r_re_d   <= r_re;
      r_busy   <= nx_busy;
    end
  end

  assign sda       = r_oe ? 1'b0 : 1'bz;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_re    = r_re;
  assign busy      = r_busy;

endmodule
